// File: rtl/pacman_game_ctrl.sv
// Pac-Man game sequencer: core reset/step pacing, one-deep move buffer, score/step budget, WIN/LOSE decision.
// Optional pause input and PAUSE state are enabled by defining PACMAN_CTRL_PAUSE_EN.
module pacman_game_ctrl #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned STEP_W    = 10,
  parameter int unsigned MAX_STEPS = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              move_valid,
  input  logic [1:0]        move_data,
  output logic              move_ready,
  input  logic [CNT_W-1:0]  candy_count,
  input  logic              catch,
`ifdef PACMAN_CTRL_PAUSE_EN
  input  logic              pause,
`endif
  output logic              core_rst,
  output logic              core_step,
  output logic [1:0]        core_move,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  score,
  output logic [STEP_W-1:0] steps,
  output logic              done,
  output logic              win
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [TICK_W-1:0]   r_tick;
  logic                r_pend_v;
  logic [1:0]          r_pend_d;
  logic [1:0]          r_last;
  logic [CNT_W-1:0]    r_score;
  logic [STEP_W-1:0]   r_steps;
  logic                r_first_play;
  logic [CNT_W-1:0]    r_candy_d;

  logic                w_ready;
  logic                w_step;
  logic [1:0]          w_sel_move;
  logic                w_accept;
  logic                w_eat;
  logic                w_timeout;

  assign w_ready    = (r_state == S_PLAY) && !r_pend_v;
  assign w_step     = (r_state == S_PLAY) && (r_tick == TICK_LAST);
  assign w_sel_move = r_pend_v ? r_pend_d : r_last;
  assign w_accept   = w_ready && move_valid;
  // A one-candy drop since last cycle means Pac-Man ate one.
  assign w_eat      = !r_first_play && (candy_count == CNT_W'(r_candy_d - 1'b1));
  assign w_timeout  = w_step && ((r_steps + 1'b1) == STEP_MAX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    core_rst   = 1'b0;
    core_step  = 1'b0;
    core_move  = 2'b00;
    move_ready = 1'b0;
    done       = 1'b0;
    win        = 1'b0;
    state      = r_state;
    score      = r_score;
    steps      = r_steps;
    case (r_state)
      S_IDLE: begin
        core_rst = 1'b1;
        if (start) w_next = S_INIT;
      end
      S_INIT: begin
        core_rst = 1'b1;
        w_next   = S_PLAY;
      end
      S_PLAY: begin
        core_step  = w_step;
        core_move  = w_step ? w_sel_move : 2'b00;
        move_ready = w_ready;
        // Exit priority: catch, then win, then step budget exhausted.
        if (catch)                                   w_next = S_LOSE;
        else if (candy_count == '0 && !r_first_play) w_next = S_WIN;
        else if (w_timeout)                          w_next = S_LOSE;
`ifdef PACMAN_CTRL_PAUSE_EN
        else if (pause)                              w_next = S_PAUSE;
`endif
      end
      S_WIN: begin
        done = 1'b1;
        win  = 1'b1;
        if (start) w_next = S_INIT;
      end
      S_LOSE: begin
        done = 1'b1;
        if (start) w_next = S_INIT;
      end
`ifdef PACMAN_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (!pause) w_next = S_PLAY;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Game datapath: new-game clear, tick pacing, move buffer, score and step counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick       <= '0;
      r_pend_v     <= 1'b0;
      r_pend_d     <= 2'b00;
      r_last       <= 2'b00;
      r_score      <= '0;
      r_steps      <= '0;
      r_first_play <= 1'b0;
      r_candy_d    <= '0;
    end else begin
      r_candy_d <= candy_count;
      if (r_state == S_INIT)      r_first_play <= 1'b1;
      else if (r_state == S_PLAY) r_first_play <= 1'b0;
      if (w_next == S_INIT) begin
        r_tick   <= '0;
        r_pend_v <= 1'b0;
        r_pend_d <= 2'b00;
        r_last   <= 2'b00;
        r_score  <= '0;
        r_steps  <= '0;
      end else if (r_state == S_PLAY) begin
        r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
        if (w_eat) r_score <= r_score + 1'b1;
        if (w_step) begin
          r_last   <= w_sel_move;
          r_pend_v <= 1'b0;
          if (r_steps != STEP_MAX) r_steps <= r_steps + 1'b1;
        end
        // An accept in a step cycle lands after the step consumed the empty buffer.
        if (w_accept) begin
          r_pend_v <= 1'b1;
          r_pend_d <= move_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Bench for pacman_game_ctrl: directed vector table, timeout/reset sequences, random run vs game-rule model.
module tb_pacman_game_ctrl;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 6;
  localparam int STEP_W   = 10;
  localparam int PH_IDLE = 0, PH_INIT = 1, PH_PLAY = 2, PH_WIN = 3, PH_LOSE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, mv, catch_i, pause;
  logic [1:0]       md;
  logic [CNT_W-1:0] cc;

  logic              a_ready, a_crst, a_step, a_done, a_win;
  logic [1:0]        a_move;
  logic [2:0]        a_state;
  logic [CNT_W-1:0]  a_score;
  logic [STEP_W-1:0] a_steps;
  logic              b_ready, b_crst, b_step, b_done, b_win;
  logic [1:0]        b_move;
  logic [2:0]        b_state;
  logic [CNT_W-1:0]  b_score;
  logic [STEP_W-1:0] b_steps;

  pacman_game_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(mv), .move_data(md),
    .move_ready(a_ready), .candy_count(cc), .catch(catch_i),
`ifdef PACMAN_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .core_rst(a_crst), .core_step(a_step), .core_move(a_move), .state(a_state),
    .score(a_score), .steps(a_steps), .done(a_done), .win(a_win)
  );

  pacman_game_ctrl #(.MAX_STEPS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .move_valid(mv), .move_data(md),
    .move_ready(b_ready), .candy_count(cc), .catch(catch_i),
`ifdef PACMAN_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .core_rst(b_crst), .core_step(b_step), .core_move(b_move), .state(b_state),
    .score(b_score), .steps(b_steps), .done(b_done), .win(b_win)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit rst, start, mv;
    bit [1:0] md;
    int cc;
    bit ct;
    int st, crst, step, mo, rdy, sc, sn;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit m, bit [1:0] d, int c, bit ct,
                              int st, int cr, int sp, int mo, int rd, int sc, int sn);
    vec_t x;
    x.rst = r; x.start = s; x.mv = m; x.md = d; x.cc = c; x.ct = ct;
    x.st = st; x.crst = cr; x.step = sp; x.mo = mo; x.rdy = rd; x.sc = sc; x.sn = sn;
    return x;
  endfunction

  // Game-rule model: one record per game, advanced once per clock.
  typedef struct {
    int ph, tick, pd, last, score, steps, cd;
    bit pv, fp;
  } mdl_t;

  function automatic bit m_step(mdl_t m);
    return (m.ph == PH_PLAY) && (m.tick == TICK_DIV - 1);
  endfunction

  function automatic int m_move(mdl_t m);
    if (!m_step(m)) return 0;
    return m.pv ? m.pd : m.last;
  endfunction

  function automatic mdl_t m_newgame(mdl_t m);
    mdl_t n = m;
    n.ph = PH_INIT; n.score = 0; n.steps = 0; n.tick = 0; n.pv = 0; n.pd = 0; n.last = 0;
    return n;
  endfunction

  function automatic mdl_t m_adv(mdl_t m, bit r, bit s, bit v, int d, int c, bit ct, int maxs);
    mdl_t n = m;
    bit stp = m_step(m);
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.cd = c;
    case (m.ph)
      PH_INIT: begin n.ph = PH_PLAY; n.fp = 1; end
      PH_PLAY: begin
        n.fp = 0;
        if (!m.fp && c == (m.cd + (1 << CNT_W) - 1) % (1 << CNT_W))
          n.score = (m.score + 1) % (1 << CNT_W);
        n.tick = (m.tick + 1) % TICK_DIV;
        if (stp) begin
          n.last = m.pv ? m.pd : m.last;
          n.pv = 0;
          if (m.steps < maxs) n.steps = m.steps + 1;
        end
        if (!m.pv && v) begin n.pv = 1; n.pd = d; end
        if (ct)                      n.ph = PH_LOSE;
        else if (c == 0 && !m.fp)    n.ph = PH_WIN;
        else if (stp && m.steps + 1 == maxs) n.ph = PH_LOSE;
      end
      default: if (s) n = m_newgame(n);
    endcase
    return n;
  endfunction

  task automatic cmp_model(input string tag, input mdl_t m,
                           input int st, input int cr, input int sp, input int mo,
                           input int rd, input int sc, input int sn, input int dn, input int wn);
    chk({tag, "_state"}, st, m.ph);
    chk({tag, "_core_rst"}, cr, int'(m.ph <= PH_INIT));
    chk({tag, "_core_step"}, sp, int'(m_step(m)));
    chk({tag, "_core_move"}, mo, m_move(m));
    chk({tag, "_ready"}, rd, int'(m.ph == PH_PLAY && !m.pv));
    chk({tag, "_score"}, sc, m.score);
    chk({tag, "_steps"}, sn, m.steps);
    chk({tag, "_done"}, dn, int'(m.ph == PH_WIN || m.ph == PH_LOSE));
    chk({tag, "_win"}, wn, int'(m.ph == PH_WIN));
  endtask

  vec_t tbl[26];

  initial begin
    int plays, pulses, r;
    mdl_t ma, mb;

    tbl[0]  = mk(0,1,0,0,40,0, 0,1,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,40,0, 1,1,0,0,0,0,0);
    tbl[2]  = mk(0,0,1,3,40,0, 2,0,0,0,1,0,0);
    tbl[3]  = mk(0,0,0,0,40,0, 2,0,0,0,0,0,0);
    tbl[4]  = mk(0,0,0,0,40,0, 2,0,0,0,0,0,0);
    tbl[5]  = mk(0,0,0,0,40,0, 2,0,1,3,0,0,0);
    tbl[6]  = mk(0,0,0,0,39,0, 2,0,0,0,1,0,1);
    tbl[7]  = mk(0,0,0,0,39,0, 2,0,0,0,1,1,1);
    tbl[8]  = mk(0,0,0,0,38,0, 2,0,0,0,1,1,1);
    tbl[9]  = mk(0,0,1,2,38,0, 2,0,1,3,1,2,1);
    tbl[10] = mk(0,0,0,0,38,0, 2,0,0,0,0,2,2);
    tbl[11] = mk(0,0,0,0,38,0, 2,0,0,0,0,2,2);
    tbl[12] = mk(0,0,0,0,38,0, 2,0,0,0,0,2,2);
    tbl[13] = mk(0,0,0,0,38,0, 2,0,1,2,0,2,2);
    tbl[14] = mk(0,0,0,0, 0,0, 2,0,0,0,1,2,3);
    tbl[15] = mk(0,0,0,0, 0,0, 3,0,0,0,0,2,3);
    tbl[16] = mk(0,0,0,0,30,0, 3,0,0,0,0,2,3);
    tbl[17] = mk(0,1,0,0,30,0, 3,0,0,0,0,2,3);
    tbl[18] = mk(0,0,0,0, 5,0, 1,1,0,0,0,0,0);
    tbl[19] = mk(0,0,0,0, 5,0, 2,0,0,0,1,0,0);
    tbl[20] = mk(0,0,0,0, 0,1, 2,0,0,0,1,0,0);
    tbl[21] = mk(0,1,0,0, 0,0, 4,0,0,0,0,0,0);
    tbl[22] = mk(0,0,0,0, 0,0, 1,1,0,0,0,0,0);
    tbl[23] = mk(0,0,0,0, 0,0, 2,0,0,0,1,0,0);
    tbl[24] = mk(1,0,0,0, 0,0, 2,0,0,0,1,0,0);
    tbl[25] = mk(0,0,0,0, 7,0, 0,1,0,0,0,0,0);

    rst = 1; start = 0; mv = 0; md = 0; cc = 40; catch_i = 0; pause = 0;
    repeat (2) @(negedge clk);

    // Directed game on the default-budget instance.
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; start = tbl[i].start; mv = tbl[i].mv; md = tbl[i].md;
      cc = CNT_W'(tbl[i].cc); catch_i = tbl[i].ct;
      chk($sformatf("vec%0d_state", i), a_state, tbl[i].st);
      chk($sformatf("vec%0d_core_rst", i), a_crst, tbl[i].crst);
      chk($sformatf("vec%0d_core_step", i), a_step, tbl[i].step);
      chk($sformatf("vec%0d_core_move", i), a_move, tbl[i].mo);
      chk($sformatf("vec%0d_ready", i), a_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_score", i), a_score, tbl[i].sc);
      chk($sformatf("vec%0d_steps", i), a_steps, tbl[i].sn);
      chk($sformatf("vec%0d_done", i), a_done, int'(tbl[i].st == PH_WIN || tbl[i].st == PH_LOSE));
      chk($sformatf("vec%0d_win", i), a_win, int'(tbl[i].st == PH_WIN));
    end

    // Step budget of 3 on the small instance: LOSE right after the third step.
    @(negedge clk); rst = 1; start = 0; mv = 0; cc = 10; catch_i = 0;
    @(negedge clk); rst = 0; start = 1;
    @(negedge clk); start = 0;
    plays = 0; pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b_state == 3'(PH_LOSE)) break;
      if (b_state == 3'(PH_PLAY)) plays++;
      if (b_step) pulses++;
    end
    chk("budget_state", b_state, PH_LOSE);
    chk("budget_steps", b_steps, 3);
    chk("budget_pulses", pulses, 3);
    chk("budget_play_cycles", plays, 12);
    chk("budget_step_in_lose", b_step, 0);
    chk("budget_done", b_done, 1);
    chk("budget_win", b_win, 0);
    chk("big_budget_still_play", a_state, PH_PLAY);
    chk("big_budget_steps", a_steps, 3);

    // Mid-game reset returns everything to reset values.
    cc = 9;
    @(negedge clk);
    chk("pre_rst_score", a_score, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_state", a_state, PH_IDLE);
    chk("midrst_core_rst", a_crst, 1);
    chk("midrst_score", a_score, 0);
    chk("midrst_steps", a_steps, 0);
    chk("midrst_ready", a_ready, 0);
    chk("midrst_step", a_step, 0);
    chk("midrst_move", a_move, 0);
    chk("midrst_done", a_done, 0);
    chk("midrst_win", a_win, 0);

    // Random play against the model on both instances.
    @(negedge clk); rst = 1; cc = 20;
    ma = '{default: 0}; mb = '{default: 0};
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      mv = 1'($urandom_range(0, 1));
      md = 2'($urandom_range(0, 3));
      catch_i = ($urandom_range(0, 99) == 0);
      r = int'($urandom_range(0, 31));
      if (r < 6 && cc > 0)               cc = cc - 1'b1;
      else if (r == 6)                   cc = CNT_W'($urandom_range(1, 40));
      else if (r >= 29 && cc == 0)       cc = CNT_W'($urandom_range(10, 30));
      cmp_model("rnd_a", ma, a_state, a_crst, a_step, a_move, a_ready, a_score, a_steps, a_done, a_win);
      cmp_model("rnd_b", mb, b_state, b_crst, b_step, b_move, b_ready, b_score, b_steps, b_done, b_win);
      ma = m_adv(ma, rst, start, mv, int'(md), int'(cc), catch_i, 1000);
      mb = m_adv(mb, rst, start, mv, int'(md), int'(cc), catch_i, 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pacman_game_ctrl.md
Name: pacman_game_ctrl

Overview:
Game sequencer for the Pac-Man grid core. It resets the core, paces it with a periodic step enable, and buffers player moves through a valid/ready handshake. It also tracks score and step budget, and decides WIN/LOSE from the core's candy count and catch flag. It sits between the player/input interface and the core, which advances only when core_step=1.

Parameters:
TICK_DIV, 4, clock cycles per game step (>=2)
CNT_W, 6, width of core candy count input
STEP_W, 10, width of step counter
MAX_STEPS, 1000, step budget before timeout loss (<2**STEP_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin/restart game (sampled in IDLE, WIN, LOSE)
move_valid  in  1  player move offered
move_data  in  2  00=up 01=down 10=left 11=right
move_ready  out  1  move accepted when valid&ready
candy_count  in  CNT_W  candies remaining, from core
catch  in  1  ghost caught Pac-Man, from core
core_rst  out  1  reset to core
core_step  out  1  one-cycle core advance enable
core_move  out  2  move applied with core_step
state  out  3  0=IDLE 1=INIT 2=PLAY 3=WIN 4=LOSE
score  out  CNT_W  candies eaten this game
steps  out  STEP_W  steps issued this game
done  out  1  state is WIN or LOSE
win  out  1  state is WIN

Behaviour:
- Clock is clk; reset is synchronous, active-high. rst in any state, mid-game included, forces IDLE next edge.
- Reset values: state=IDLE, core_step=0, core_move=00, move_ready=0, score=0, steps=0, done=0, win=0, core_rst=1. Pending and last-move buffers are cleared; last move=00.
- core_rst=1 in IDLE and INIT, else 0. done, win and move_ready are decoded from registered state and buffer; no combinational input-to-output paths.
- IDLE: start=1 -> INIT.
- INIT: lasts exactly 1 cycle, then PLAY.
  - Clears score, steps, tick counter, pending buffer; last move=00.
- PLAY:
  - Tick counter runs 0..TICK_DIV-1, then wraps.
  - core_step=1 for the single cycle where tick==TICK_DIV-1, so the first step occurs on the TICK_DIV-th PLAY cycle.
  - core_move during core_step = pending move if pending valid, else last move (repeat).
  - On core_step: last move<=core_move, pending cleared, steps+1.
- Move handshake: move_ready = (state==PLAY) && !pending_valid.
  - On accept, move_data is latched into pending.
  - Accept and core_step in the same cycle: pending was empty, so the step uses last move. The new move applies at the next step.
  - Only one pending move is held; a further move_valid sees ready=0 until consumed. move_valid outside PLAY is ignored.
- Score: first_play flag is set on the INIT->PLAY cycle. In any PLAY cycle with first_play=0 and candy_count == candy_count_d-1 (registered previous value), score+1. candy_count_d updates every cycle.
- Exits from PLAY, evaluated every cycle (first PLAY cycle included for catch only), priority highest first:
  1. catch=1 -> LOSE.
  2. candy_count==0 with first_play=0 -> WIN.
  3. A core_step that makes steps==MAX_STEPS -> LOSE. Catch or win detected in that same cycle still takes priority.
- WIN/LOSE: core_step=0. score and steps hold. start=1 -> INIT (restart); otherwise hold.
- Counters never wrap: steps saturates at MAX_STEPS. score cannot exceed initial count by construction.

Optional Feature:
PACMAN_CTRL_PAUSE_EN: adds input pause (1 bit) and state encoding 5=PAUSE.
- PLAY with pause=1 -> PAUSE. PAUSE with pause=0 -> PLAY.
- In PAUSE: tick counter, pending and last move frozen; core_step=0; move_ready=0; catch/win/timeout not evaluated; score not updated; candy_count_d still tracks.
- rst still overrides.
Without the macro: no pause port, and encoding 5 is never produced.

Test Plan:
- rst, start pulse, TICK_DIV=4, no moves -> INIT 1 cycle; core_rst high through INIT; core_step first on PLAY cycle 4, then every 4 cycles; core_move=00; steps=1,2,3.
- move_valid=1, move_data=11 on PLAY cycle 1 -> accepted (ready=1); ready=0 until next step; that step drives core_move=11; later steps repeat 11.
- move_valid with move_data=10 in the exact core_step cycle, pending empty -> that step uses last move; next step uses 10.
- candy_count sequence 40,39,39,38 during PLAY -> score=2; candy_count->0 -> WIN next cycle, done=1, win=1, core_step stays 0.
- catch=1 and candy_count=0 in the same PLAY cycle -> LOSE (win=0). start in LOSE -> INIT; score=0, steps=0.
- MAX_STEPS=3, no catch, candy_count constant 10 -> LOSE immediately after the 3rd core_step, steps=3. rst asserted mid-PLAY -> IDLE next cycle, core_rst=1, all outputs at reset values.
